// File: rtl/zbuf_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zbuf_frame_sched
// Description : Frame-level scheduler for the Bresenham/z-buffer line drawer.
//               Runs a z clear pass over the RAM on frame start. It then pops
//               queued line jobs and issues them to the drawer one at a time.
//               It also owns the single RAM write port.
//               Optional macro ZBUF_CLEAR_COLOR_EN also clears the colour RAM
//               to BG_RGB during the clear pass.
// Revision    : 1.0 - initial release
// ============================================================================
module zbuf_frame_sched #(
    parameter int          ADDR_W     = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  Z_FAR      = 8'hFF,
    parameter logic [23:0] BG_RGB     = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [23:0]       job_a,
    input  logic [23:0]       job_b,
    input  logic [23:0]       job_rgb,
    output logic              drw_req,
    input  logic              drw_ack,
    output logic [23:0]       drw_point_a,
    output logic [23:0]       drw_point_b,
    output logic [23:0]       drw_rgb,
    input  logic [ADDR_W-1:0] drw_waddr,
    input  logic              drw_we,
    input  logic              drw_wez,
    input  logic [7:0]        drw_zdata,
    input  logic [7:0]        drw_rdata,
    input  logic [7:0]        drw_gdata,
    input  logic [7:0]        drw_bdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_we,
    output logic              mem_wez,
    output logic [7:0]        mem_zdata,
    output logic [7:0]        mem_rdata,
    output logic [7:0]        mem_gdata,
    output logic [7:0]        mem_bdata,
    output logic              busy,
    output logic              frame_done
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]  c_full    = (c_ptr_w+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] c_clr_last = {ADDR_W{1'b1}};

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_clear    = 3'd1;
    localparam logic [2:0] c_st_fetch    = 3'd2;
    localparam logic [2:0] c_st_issue    = 3'd3;
    localparam logic [2:0] c_st_wait_ack = 3'd4;
    localparam logic [2:0] c_st_done     = 3'd5;

`ifdef ZBUF_CLEAR_COLOR_EN
    localparam logic        c_clr_we  = 1'b1;
    localparam logic [23:0] c_clr_rgb = BG_RGB;
`else
    localparam logic        c_clr_we  = 1'b0;
    localparam logic [23:0] c_clr_rgb = 24'h000000;
    // Background colour has no consumer when only z is cleared.
    logic w_unused_bg;
    assign w_unused_bg = ^BG_RGB;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_clr;
    logic               r_frame_end;
    logic [71:0]        r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Readiness comes from the registered count, so a pop in the same cycle
    // does not open a slot for a push until the following cycle.
    assign job_ready = (r_count != c_full);
    assign w_push    = job_valid && job_ready;
    assign w_pop     = (r_state == c_st_fetch) && (r_count != '0);

    // Job FIFO storage (data needs no reset; validity is tracked by count).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {job_a, job_b, job_rgb};
        end
    end

    // Job FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear address counter, sticky frame_end flag and latched drawer job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr       <= '0;
            r_frame_end <= 1'b0;
            drw_point_a <= '0;
            drw_point_b <= '0;
            drw_rgb     <= '0;
        end else begin
            if (r_state == c_st_idle && frame_start) begin
                r_clr <= '0;
            end else if (r_state == c_st_clear) begin
                r_clr <= r_clr + ADDR_W'(1);
            end

            if (r_state == c_st_done) begin
                r_frame_end <= 1'b0;
            end else if (frame_end && (r_state != c_st_idle || frame_start)) begin
                r_frame_end <= 1'b1;
            end

            if (w_pop) begin
                {drw_point_a, drw_point_b, drw_rgb} <= r_fifo[r_rptr];
            end
        end
    end

    // Next-state logic, handshake/status outputs and write-port mux.
    always_comb begin
        w_state_nxt = r_state;
        drw_req     = 1'b0;
        frame_done  = 1'b0;
        busy        = (r_state != c_st_idle);
        mem_waddr   = '0;
        mem_we      = 1'b0;
        mem_wez     = 1'b0;
        mem_zdata   = 8'h00;
        mem_rdata   = 8'h00;
        mem_gdata   = 8'h00;
        mem_bdata   = 8'h00;
        case (r_state)
            c_st_idle: begin
                if (frame_start) w_state_nxt = c_st_clear;
            end
            c_st_clear: begin
                mem_waddr = r_clr;
                mem_wez   = 1'b1;
                mem_zdata = Z_FAR;
                mem_we    = c_clr_we;
                {mem_rdata, mem_gdata, mem_bdata} = c_clr_rgb;
                if (r_clr == c_clr_last) w_state_nxt = c_st_fetch;
            end
            c_st_fetch: begin
                if (r_count != '0)    w_state_nxt = c_st_issue;
                else if (r_frame_end) w_state_nxt = c_st_done;
            end
            c_st_issue: begin
                drw_req     = 1'b1;
                w_state_nxt = c_st_wait_ack;
            end
            c_st_wait_ack: begin
                mem_waddr = drw_waddr;
                mem_we    = drw_we;
                mem_wez   = drw_wez;
                mem_zdata = drw_zdata;
                mem_rdata = drw_rdata;
                mem_gdata = drw_gdata;
                mem_bdata = drw_bdata;
                if (drw_ack) w_state_nxt = c_st_fetch;
            end
            c_st_done: begin
                frame_done  = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_zbuf_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_zbuf_frame_sched
// Description : Scoreboard bench for zbuf_frame_sched (ADDR_W=4, 4-deep FIFO).
//               Expected RAM writes, drawer requests and frame_done pulses are
//               queued when stimulus is issued; a negedge monitor pops and
//               compares them whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zbuf_frame_sched;

    localparam int          c_addr_w = 4;
    localparam logic [23:0] c_bg     = 24'h102030;
    localparam int          c_ww     = 2 + c_addr_w + 8 + 24;
`ifdef ZBUF_CLEAR_COLOR_EN
    localparam logic        c_clr_we  = 1'b1;
    localparam logic [23:0] c_clr_rgb = c_bg;
`else
    localparam logic        c_clr_we  = 1'b0;
    localparam logic [23:0] c_clr_rgb = 24'h000000;
`endif

    logic clk = 1'b0;
    logic rst, frame_start, frame_end, job_valid, job_ready;
    logic [23:0] job_a, job_b, job_rgb;
    logic drw_req, drw_ack;
    logic [23:0] drw_point_a, drw_point_b, drw_rgb;
    logic [c_addr_w-1:0] drw_waddr, mem_waddr;
    logic drw_we, drw_wez, mem_we, mem_wez;
    logic [7:0] drw_zdata, drw_rdata, drw_gdata, drw_bdata;
    logic [7:0] mem_zdata, mem_rdata, mem_gdata, mem_bdata;
    logic busy, frame_done;

    int total = 0;
    int bad   = 0;
    logic [c_ww-1:0] q_wr[$];
    logic [71:0]     q_req[$];
    bit              q_done[$];
    bit mon_en   = 1'b0;
    bit noise_on = 1'b0;

    always #5 clk = ~clk;

    zbuf_frame_sched #(
        .ADDR_W(c_addr_w), .FIFO_DEPTH(4), .Z_FAR(8'hFF), .BG_RGB(c_bg)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .job_rgb(job_rgb),
        .drw_req(drw_req), .drw_ack(drw_ack),
        .drw_point_a(drw_point_a), .drw_point_b(drw_point_b), .drw_rgb(drw_rgb),
        .drw_waddr(drw_waddr), .drw_we(drw_we), .drw_wez(drw_wez),
        .drw_zdata(drw_zdata), .drw_rdata(drw_rdata), .drw_gdata(drw_gdata),
        .drw_bdata(drw_bdata),
        .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wez(mem_wez),
        .mem_zdata(mem_zdata), .mem_rdata(mem_rdata), .mem_gdata(mem_gdata),
        .mem_bdata(mem_bdata),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drawer-side background activity that must never leak onto the RAM port
    // outside WAIT_ACK.
    task automatic set_noise();
        drw_we    = noise_on;
        drw_wez   = noise_on;
        drw_waddr = 4'hA;
        drw_zdata = 8'h11;
        drw_rdata = 8'h55;
        drw_gdata = 8'h55;
        drw_bdata = 8'h55;
    endtask

    task automatic expect_clear();
        for (int i = 0; i < (1 << c_addr_w); i++)
            q_wr.push_back({c_clr_we, 1'b1, c_addr_w'(i), 8'hFF, c_clr_rgb});
    endtask

    task automatic push_job(input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] rgb, input bit exp_ok, input bit add_exp);
        job_a = a; job_b = b; job_rgb = rgb; job_valid = 1'b1;
        check("job_ready_at_push", job_ready, exp_ok);
        if (exp_ok && add_exp) q_req.push_back({a, b, rgb});
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!drw_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drw_req_seen", drw_req, 1'b1);
    endtask

    // Drawer model: three writes at the start of the line, ack on cycle 40.
    task automatic serve();
        wait_req();
        tick();
        check("busy_in_wait_ack", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            q_wr.push_back({1'b1, 1'b1, c_addr_w'(8 + k), 8'(8'h40 + k), 24'h717273});
            drw_we = 1'b1; drw_wez = 1'b1; drw_waddr = c_addr_w'(8 + k);
            drw_zdata = 8'(8'h40 + k);
            drw_rdata = 8'h71; drw_gdata = 8'h72; drw_bdata = 8'h73;
            tick();
        end
        drw_we = 1'b0; drw_wez = 1'b0;
        repeat (36) tick();
        drw_ack = 1'b1;
        tick();
        drw_ack = 1'b0;
        set_noise();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("returned_to_idle", busy, 1'b0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we || mem_wez) begin
                if (q_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr=%0h we=%0b wez=%0b z=%0h expected none",
                             mem_waddr, mem_we, mem_wez, mem_zdata);
                end else begin
                    check("mem_write", {mem_we, mem_wez, mem_waddr, mem_zdata,
                                        mem_rdata, mem_gdata, mem_bdata}, q_wr.pop_front());
                end
            end
            if (drw_req) begin
                if (q_req.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got a=%0h b=%0h rgb=%0h expected none",
                             drw_point_a, drw_point_b, drw_rgb);
                end else begin
                    check("drw_req_job", {drw_point_a, drw_point_b, drw_rgb}, q_req.pop_front());
                end
            end
            if (frame_done) begin
                if (q_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame_done: got 1 expected 0");
                end else begin
                    check("frame_done", frame_done, q_done.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; frame_start = 1'b0; frame_end = 1'b0; job_valid = 1'b0;
        job_a = '0; job_b = '0; job_rgb = '0; drw_ack = 1'b0;
        set_noise();
        tick(); tick();
        check("rst_busy", busy, 1'b0);
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_drw_req", drw_req, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_mem_wez", mem_wez, 1'b0);
        check("rst_point_a", drw_point_a, 24'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        noise_on = 1'b1;
        set_noise();

        // Empty frame, frame_end two cycles after start, ack noise in CLEAR.
        expect_clear();
        q_done.push_back(1'b1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        drw_ack = 1'b1; tick(); drw_ack = 1'b0;
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        wait_idle();

        // One job pushed during CLEAR.
        expect_clear();
        q_done.push_back(1'b1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        push_job(24'h323215, 24'h403219, 24'hAABBCC, 1'b1, 1'b1);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        serve();
        wait_idle();

        // Fill the FIFO in IDLE; the fifth push is refused.
        push_job(24'h010203, 24'h040506, 24'h111111, 1'b1, 1'b1);
        push_job(24'h0A0B0C, 24'h0D0E0F, 24'h222222, 1'b1, 1'b1);
        push_job(24'h102030, 24'h405060, 24'h333333, 1'b1, 1'b1);
        push_job(24'hA0B0C0, 24'hD0E0F0, 24'h444444, 1'b1, 1'b1);
        push_job(24'hEEEEEE, 24'hDDDDDD, 24'h555555, 1'b0, 1'b1);
        check("job_ready_full", job_ready, 1'b0);
        expect_clear();
        q_done.push_back(1'b1);
        frame_start = 1'b1; frame_end = 1'b1; tick();
        frame_start = 1'b0; frame_end = 1'b0;
        for (int j = 0; j < 4; j++) serve();
        wait_idle();

        // Stray ack while parked in FETCH.
        expect_clear();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (18) tick();
        drw_ack = 1'b1; tick(); drw_ack = 1'b0;
        tick();
        check("fetch_busy_after_ack", busy, 1'b1);
        check("fetch_no_req", drw_req, 1'b0);
        check("fetch_mux_quiet", mem_wez, 1'b0);
        push_job(24'h112233, 24'h445566, 24'h778899, 1'b1, 1'b1);
        serve();
        q_done.push_back(1'b1);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        wait_idle();

        // Reset in WAIT_ACK with a second job still queued, then a late ack.
        noise_on = 1'b0;
        set_noise();
        push_job(24'h050505, 24'h060606, 24'h070707, 1'b1, 1'b1);
        push_job(24'h080808, 24'h090909, 24'h0A0A0A, 1'b1, 1'b0);
        expect_clear();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_req();
        tick(); tick(); tick();
        rst = 1'b0; tick(); tick(); rst = 1'b1;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_req", drw_req, 1'b0);
        check("post_rst_job_ready", job_ready, 1'b1);
        check("post_rst_point_a", drw_point_a, 24'h0);
        drw_ack = 1'b1; tick(); drw_ack = 1'b0; tick();
        check("late_ack_busy", busy, 1'b0);
        check("late_ack_req", drw_req, 1'b0);
        expect_clear();
        q_done.push_back(1'b1);
        frame_start = 1'b1; frame_end = 1'b1; tick();
        frame_start = 1'b0; frame_end = 1'b0;
        wait_idle();

        repeat (5) tick();
        check("left_writes", q_wr.size(), 0);
        check("left_reqs", q_req.size(), 0);
        check("left_dones", q_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zbuf_frame_sched.md
Name: zbuf_frame_sched

Overview:
- Frame-level scheduler in front of the Bresenham/z-buffer line drawer.
- On frame start it runs a clear pass over the z RAM, and optionally the colour RAM.
- It then pops queued line jobs from an internal FIFO and issues each one to the drawer over the req/ack handshake, one line at a time.
- It owns the single RAM write port: a mux selects between the clear engine and the drawer.

Parameters:
- ADDR_W, 16, RAM address width; the clear pass covers 2**ADDR_W words.
- FIFO_DEPTH, 4, job FIFO entries (power of 2, at least 2).
- Z_FAR, 8'hFF, depth value written during clear.
- BG_RGB, 24'h000000, background colour written during clear (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- frame_start  in  1  pulse: begin a new frame (accepted only in IDLE)
- frame_end  in  1  pulse: no more jobs for this frame; sticky until the frame completes
- job_valid  in  1  job write strobe
- job_ready  out  1  FIFO not full
- job_a  in  24  line endpoint A {x[23:16], y[15:8], z[7:0]}
- job_b  in  24  line endpoint B, same format
- job_rgb  in  24  line colour
- drw_req  out  1  one-cycle start pulse to the drawer
- drw_ack  in  1  one-cycle pulse from the drawer: line finished
- drw_point_a  out  24  registered endpoint A
- drw_point_b  out  24  registered endpoint B
- drw_rgb  out  24  registered colour
- drw_waddr  in  ADDR_W  drawer write address
- drw_we  in  1  drawer colour write enable
- drw_wez  in  1  drawer z write enable
- drw_zdata  in  8  drawer z data
- drw_rdata, drw_gdata, drw_bdata  in  8 each  drawer colour data
- mem_waddr  out  ADDR_W  muxed write address
- mem_we  out  1  muxed colour write enable
- mem_wez  out  1  muxed z write enable
- mem_zdata  out  8  muxed z data
- mem_rdata, mem_gdata, mem_bdata  out  8 each  muxed colour data
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (rst=0 at a clk edge):
  - state goes to IDLE; FIFO empties; frame_end flag clears; clear counter goes to 0.
  - All outputs go to 0, except job_ready=1.
  - Reset mid-operation aborts the clear or draw immediately. An outstanding drw_ack arriving after reset is ignored.
- FIFO:
  - Push when job_valid && job_ready, storing {job_a, job_b, job_rgb}.
  - Pushes are accepted in every state, including IDLE and CLEAR.
  - Push while full is dropped; job_ready=0 when full.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, but job_ready is registered off the current count, so the push is still refused that cycle.
- States:
  - IDLE: frame_start goes to CLEAR with counter=0. frame_start in any other state is ignored.
  - CLEAR:
    - Each cycle drives mem_waddr=counter, mem_wez=1, mem_zdata=Z_FAR, then counter increments.
    - At counter = 2**ADDR_W-1 the last write happens and the state goes to FETCH. Counter wraps to 0.
    - Exactly 2**ADDR_W cycles; no address skipped or repeated.
    - Drawer inputs are ignored during CLEAR.
  - FETCH:
    - FIFO non-empty: pop, latch drw_point_a/b and drw_rgb, go to ISSUE.
    - FIFO empty and frame_end flag set: go to DONE.
    - Otherwise stay in FETCH.
  - ISSUE: drw_req=1 for exactly one cycle, go to WAIT_ACK. drw_point_*/drw_rgb stay stable until the next pop.
  - WAIT_ACK:
    - The mem_* outputs follow the drawer inputs combinationally.
    - On drw_ack go to FETCH, so back-to-back jobs have 2 cycles of gap: FETCH, ISSUE.
    - drw_ack in any other state is ignored.
  - DONE: frame_done=1 for one cycle, frame_end flag clears, go to IDLE.
- Write-port mux:
  - CLEAR: clear engine drives the port.
  - WAIT_ACK: drawer drives the port.
  - All other states: mem_we=mem_wez=0, address and data 0.
- frame_end:
  - A frame_end pulse sets a sticky flag in any non-IDLE state.
  - A frame_end pulse in the same cycle as frame_start (IDLE) is also captured.

Optional Feature:
- Macro: ZBUF_CLEAR_COLOR_EN.
- Defined: during CLEAR, mem_we=1 and {mem_rdata, mem_gdata, mem_bdata}=BG_RGB, so colour and z are cleared in the same pass.
- Undefined: during CLEAR, mem_we=0 and the colour data outputs are 0; only z is cleared. BG_RGB is unused.

Test Plan:
- ADDR_W=4, frame_start with FIFO empty and frame_end pulsed 2 cycles later → 16 consecutive wez writes at addresses 0..15 with zdata=FF, then frame_done exactly once.
- Push job a=24'h323215, b=24'h403219, rgb=24'hAABBCC during CLEAR → after CLEAR, drw_req pulses once with those exact values; a drawer model acks after 40 cycles; its wez/waddr appear on mem_* only during WAIT_ACK.
- Push 4 jobs with FIFO_DEPTH=4, then a fifth → job_ready=0 and the fifth is dropped; exactly 4 drw_req pulses issue in FIFO order.
- drw_ack injected during CLEAR and FETCH → no state change; the drawer's drw_wez during CLEAR never reaches mem_wez.
- Assert rst=0 mid-WAIT_ACK, release, send a late drw_ack → busy=0, no drw_req, FIFO empty, job_ready=1.
- Build with ZBUF_CLEAR_COLOR_EN and BG_RGB=24'h102030 → during CLEAR, mem_we=1 with r/g/b=10/20/30; without the macro, mem_we=0 throughout CLEAR.
